// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, the NOP used for
// misalignment traps, and the fetch buffer entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO (DEPTH a power of two) with a flush that
// empties it in one edge and overrides any simultaneous push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [ENTRY_W-1:0]     head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_count != '0);

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, responses buffered for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned PCs instead of forcing alignment.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_we,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  r_state;
  logic [31:0]   r_req_pc;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_room;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Only IDLE can issue, so nothing is outstanding when the room check runs.
  assign w_room = w_count < DEPTH_C;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halt;
  logic w_misaligned;
  logic w_trap;

  assign w_misaligned = pc[1:0] != 2'b00;
  assign w_trap   = rst && (r_state == S_IDLE) && !flush && w_room && !r_halt && w_misaligned;
  assign w_issue  = rst && (r_state == S_IDLE) && !flush && w_room && !r_halt && !w_misaligned;
  assign mem_addr = pc;
  assign w_push   = ((r_state == S_WAIT) && mem_rvalid && !flush) || w_trap;
`else
  assign w_issue  = rst && (r_state == S_IDLE) && !flush && w_room;
  assign mem_addr = {pc[31:2], 2'b00};
  assign w_push   = (r_state == S_WAIT) && mem_rvalid && !flush;
`endif

  always_comb begin
    w_push_entry          = '0;
    w_push_entry.pc       = r_req_pc;
    w_push_entry.instr    = mem_rdata;
    w_push_entry.misalign = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (w_trap) begin
      w_push_entry.pc       = pc;
      w_push_entry.instr    = NOP_INSTR;
      w_push_entry.misalign = 1'b1;
    end
`endif
  end

  // A flush in WAIT with no response yet leaves one read in flight that DROP swallows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_req_pc <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_halt   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue && mem_gnt) begin
            r_req_pc <= pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid)  r_state <= S_IDLE;
          else if (flush)  r_state <= S_DROP;
        end
        S_DROP: begin
          if (mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (flush)       r_halt <= 1'b0;
      else if (w_trap) r_halt <= 1'b1;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data(w_push_entry),
    .pop      (w_pop),
    .flush    (flush),
    .count    (w_count),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign mem_req  = w_issue;
  assign pc_we    = w_issue && mem_gnt;
  assign w_pop    = !w_empty && id_ready;
  assign id_valid = !w_empty;
  assign id_instr = w_empty ? '0 : w_head.instr;
  assign id_pc    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign id_misalign = w_empty ? 1'b0 : w_head.misalign;
`else
  logic w_unused;
  assign w_unused = w_head.misalign;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-002 Port: clk  in  1  single clock, rising-edge.
REQ-003 Port: rst  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: pc  in  32  current program counter from the PC block.
REQ-005 Port: pc_we  out  1  advance PC to pc+4 (drives PC block write enable).
REQ-006 Port: flush  in  1  redirect: PC is loaded with a non-sequential target this cycle.
REQ-007 Port: mem_req  out  1  instruction memory read request.
REQ-008 Port: mem_addr  out  32  read address.
REQ-009 Port: mem_gnt  in  1  memory accepts the request this cycle.
REQ-010 Port: mem_rvalid  in  1  read data valid.
REQ-011 Port: mem_rdata  in  32  instruction word.
REQ-012 Port: id_valid  out  1  buffered instruction available to decode.
REQ-013 Port: id_ready  in  1  decode accepts the instruction.
REQ-014 Port: id_instr / id_pc  out  32 each  instruction and its address.
REQ-015 Port: id_misalign  out  1  fetch address misaligned (present only with macro, REQ-034).

Function
REQ-016 FSM states IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-017 IDLE: mem_req = !flush && (count + 0) < DEPTH; mem_addr = pc.
REQ-018 pc_we = mem_req && mem_gnt; on that edge, latch pc as req_pc, go WAIT.
REQ-019 mem_req without mem_gnt: hold mem_req and mem_addr, stay IDLE.
REQ-020 WAIT: mem_req = 0; on mem_rvalid push {req_pc, mem_rdata} to buffer, go IDLE.
REQ-021 WAIT with flush: go DROP; if mem_rvalid in the same cycle, discard data, go IDLE instead.
REQ-022 DROP: mem_req = 0; on mem_rvalid discard data, go IDLE; further flush keeps DROP.
REQ-023 flush in any state empties the buffer the same edge; any simultaneous pop is ignored.
REQ-024 Minimum latency: grant at cycle N, rvalid at N+1, id_valid at N+2.
REQ-025 Buffer FIFO order; id_valid = !empty; pop on id_valid && id_ready; id_instr/id_pc are the head entry.
REQ-026 Issue only when count + outstanding < DEPTH, so a push never hits a full buffer; push and pop in the same cycle allowed, count unchanged.
REQ-027 mem_rvalid in IDLE is ignored, e.g. a stale response after reset.
REQ-028 Count arithmetic is $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.

Reset
REQ-029 While rst is low: state IDLE, buffer empty, req_pc 0.
REQ-030 While rst is low: mem_req 0, pc_we 0, id_valid 0, id_instr 0, id_pc 0, id_misalign 0.
REQ-031 Reset mid-transaction abandons the outstanding request with no DROP state.
REQ-032 First request is issued on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN selects misalignment handling.
REQ-034 Defined, IDLE with pc[1:0] != 0 and room available: no mem_req; pc_we = 0; push {pc, 32'h00000013, misalign=1} once; then halt issuing until flush.
REQ-035 Undefined: id_misalign port absent; mem_addr = {pc[31:2], 2'b00}; no check.

Structure
REQ-036 Package fetch_pkg: FSM state enum, NOP constant 32'h00000013, buffer entry struct {pc, instr, misalign}.
REQ-037 Sub-module fetch_fifo: parameterised DEPTH FIFO with push, pop, flush, count, head.

Verification
REQ-038 pc=0x100, gnt=1, rvalid one cycle later with 0x00500093, id_ready=1 -> pc_we one cycle; id_valid at N+2 with id_pc=0x100, id_instr=0x00500093.
REQ-039 id_ready=0, three sequential fetches -> exactly 2 grants, mem_req low while full; mem_req resumes the cycle after the first pop.
REQ-040 flush in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> never on id_instr; next mem_addr = new pc 0x200.
REQ-041 flush with 2 valid entries and id_ready=1 -> id_valid=0 next cycle, count 0.
REQ-042 rst low during WAIT, then rvalid after release -> response ignored; first id_pc is the post-reset pc.
REQ-043 FETCH_MISALIGN_TRAP_EN, pc=0x102 -> no mem_req; one entry id_misalign=1, id_instr=0x00000013, id_pc=0x102.
